regfile_write_arbiter: RTL and testbench

//  Shares the register file's two write ports among NUM_REQ writeback sources (ALU, load, mul, ...).
//  - Round-robin picks up to two writes per cycle and registers them onto port 1 / port 2.
//  - Enforces the file's single first_byte_only and distinct-address rules.
//  - Exports a pending-write mask for hazard logic.

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_rr_pick_two.sv | 68 ++++++
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and the round-robin index wrap helper used by
// the write arbiter and its picker.
package regfile_write_arbiter_pkg;

    localparam int          RF_DATA_W   = 16;
    localparam int          RF_ADDR_W   = 4;
    localparam int          RF_NUM_REGS = 16;
    localparam logic [3:0]  RF_LINK_REG = 4'hF;

    // Reduces ptr+offset back into 0..n-1; inputs never exceed 2n-2.
    function automatic logic [3:0] rr_wrap(input logic [3:0] sum, input logic [3:0] n);
        if (sum >= n) begin
            rr_wrap = sum - n;
        end else begin
            rr_wrap = sum;
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick_two.sv
// Combinational round-robin picker: first valid request from the pointer wins
// slot A, the next one with a different address and the same byte mode wins B.
module rr_pick_two
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int PTR_W   = 2
)(
    input  logic [NUM_REQ-1:0]        i_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ-1:0]        i_byte,
    input  logic [PTR_W-1:0]          i_ptr,
    output logic [NUM_REQ-1:0]        o_grant_a,
    output logic [NUM_REQ-1:0]        o_grant_b,
    output logic [PTR_W-1:0]          o_idx_a,
    output logic [PTR_W-1:0]          o_idx_b,
    output logic                      o_found_a,
    output logic                      o_found_b,
    output logic                      o_other_valid
);

    logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
    logic [3:0]        w_sum;
    logic [PTR_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_a_addr;
    logic              w_a_byte;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = i_addr[g*ADDR_W +: ADDR_W];
    end

    // Scan in rotated order; any valid request after A that fails to pair is a rule loss
    always_comb begin
        o_grant_a     = {NUM_REQ{1'b0}};
        o_grant_b     = {NUM_REQ{1'b0}};
        o_idx_a       = {PTR_W{1'b0}};
        o_idx_b       = {PTR_W{1'b0}};
        o_found_a     = 1'b0;
        o_found_b     = 1'b0;
        o_other_valid = 1'b0;
        w_a_addr      = {ADDR_W{1'b0}};
        w_a_byte      = 1'b0;
        w_sum         = 4'd0;
        w_idx         = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = 4'(i_ptr) + 4'(k);
            w_idx = PTR_W'(rr_wrap(w_sum, 4'(NUM_REQ)));
            if (!i_valid[w_idx]) begin
                w_a_byte = w_a_byte;
            end else if (!o_found_a) begin
                o_found_a        = 1'b1;
                o_idx_a          = w_idx;
                o_grant_a[w_idx] = 1'b1;
                w_a_addr         = w_addr_arr[w_idx];
                w_a_byte         = i_byte[w_idx];
            end else if (!o_found_b && (w_addr_arr[w_idx] != w_a_addr)
                         && (i_byte[w_idx] == w_a_byte)) begin
                o_found_b        = 1'b1;
                o_idx_b          = w_idx;
                o_grant_b[w_idx] = 1'b1;
            end else begin
                o_other_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's two write ports among NUM_REQ writeback sources,
// registering up to two round-robin grants per cycle onto ports 1 and 2.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
)(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_hold,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_byte,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_write_enable_1,
    output logic [ADDR_W-1:0]         o_write_addr_1,
    output logic [DATA_W-1:0]         o_write_data_1,
    output logic                      o_write_enable_2,
    output logic [ADDR_W-1:0]         o_write_addr_2,
    output logic [DATA_W-1:0]         o_write_data_2,
    output logic                      o_first_byte_only,
    output logic [(1<<ADDR_W)-1:0]    o_pending_mask,
    output logic                      o_conflict
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0] w_data_arr [NUM_REQ];

    logic [NUM_REQ-1:0] w_grant_a, w_grant_b;
    logic [PTR_W-1:0]   w_idx_a, w_idx_b, w_last;
    logic               w_found_a, w_found_b, w_other_valid;
    logic               w_go, w_accept;

    logic [PTR_W-1:0]   r_ptr, w_ptr_nx;
    logic               r_en1, r_en2, r_byte, r_conflict;
    logic [ADDR_W-1:0]  r_addr1, r_addr2, w_addr1_nx, w_addr2_nx;
    logic [DATA_W-1:0]  r_data1, r_data2, w_data1_nx, w_data2_nx;
    logic               w_byte_nx;
    logic [NREG-1:0]    r_pending, w_pend_nx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
        assign w_data_arr[g] = i_req_data[g*DATA_W +: DATA_W];
    end

    rr_pick_two #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_valid       (i_req_valid),
        .i_addr        (i_req_addr),
        .i_byte        (i_req_byte),
        .i_ptr         (r_ptr),
        .o_grant_a     (w_grant_a),
        .o_grant_b     (w_grant_b),
        .o_idx_a       (w_idx_a),
        .o_idx_b       (w_idx_b),
        .o_found_a     (w_found_a),
        .o_found_b     (w_found_b),
        .o_other_valid (w_other_valid)
    );

    assign w_go        = !i_hold && !i_rst;
    assign w_accept    = w_go && w_found_a;
    assign o_req_ready = (w_grant_a | w_grant_b) & {NUM_REQ{w_go}};

    // Next issue-stage contents; payload fields hold when their slot is not granted
    always_comb begin
        w_addr1_nx = r_addr1;
        w_data1_nx = r_data1;
        w_addr2_nx = r_addr2;
        w_data2_nx = r_data2;
        w_byte_nx  = r_byte;
        w_ptr_nx   = r_ptr;
        w_last     = w_found_b ? w_idx_b : w_idx_a;
        if (w_accept) begin
            w_addr1_nx = w_addr_arr[w_idx_a];
            w_data1_nx = w_data_arr[w_idx_a];
            w_byte_nx  = i_req_byte[w_idx_a];
            w_ptr_nx   = PTR_W'(rr_wrap(4'(w_last) + 4'd1, 4'(NUM_REQ)));
            if (w_found_b) begin
                w_addr2_nx = w_addr_arr[w_idx_b];
                w_data2_nx = w_data_arr[w_idx_b];
            end else begin
                w_addr2_nx = r_addr2;
            end
        end else begin
            w_ptr_nx = r_ptr;
        end
        w_pend_nx = (w_accept ? (NREG'(1) << w_addr1_nx) : {NREG{1'b0}})
                  | ((w_accept && w_found_b) ? (NREG'(1) << w_addr2_nx) : {NREG{1'b0}});
    end

    // Issue registers, round-robin pointer and conflict pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= {PTR_W{1'b0}};
            r_en1      <= 1'b0;
            r_en2      <= 1'b0;
            r_addr1    <= {ADDR_W{1'b0}};
            r_addr2    <= {ADDR_W{1'b0}};
            r_data1    <= {DATA_W{1'b0}};
            r_data2    <= {DATA_W{1'b0}};
            r_byte     <= 1'b0;
            r_pending  <= {NREG{1'b0}};
            r_conflict <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nx;
            r_en1      <= w_accept;
            r_en2      <= w_accept && w_found_b;
            r_addr1    <= w_addr1_nx;
            r_addr2    <= w_addr2_nx;
            r_data1    <= w_data1_nx;
            r_data2    <= w_data2_nx;
            r_byte     <= w_byte_nx;
            r_pending  <= w_pend_nx;
            r_conflict <= w_accept && !w_found_b && w_other_valid;
        end
    end

    assign o_write_enable_1  = r_en1;
    assign o_write_addr_1    = r_addr1;
    assign o_write_data_1    = r_data1;
    assign o_write_enable_2  = r_en2;
    assign o_write_addr_2    = r_addr2;
    assign o_write_data_2    = r_data2;
    assign o_first_byte_only = r_byte;
    assign o_pending_mask    = r_pending;
    assign o_conflict        = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with a scoreboard of expected
// issue-stage contents, plus reset, hold and mid-flight reset sequences.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [15:0] req_addr = 16'h0;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  req_byte = 4'h0;
    logic [3:0]  req_ready;
    logic        we1, we2, fbo, conflict;
    logic [3:0]  wa1, wa2;
    logic [15:0] wd1, wd2, pend;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        hold;
        logic [3:0]  valid;
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  byt;
        int          a;
        int          b;
        logic        conf;
    } vec_t;

    typedef struct packed {
        logic        en1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        en2;
        logic [3:0]  a2;
        logic [15:0] d2;
        logic        fbo;
        logic [15:0] pend;
        logic        conf;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    logic [3:0]  last_a1 = 4'h0, last_a2 = 4'h0;
    logic [15:0] last_d1 = 16'h0, last_d2 = 16'h0;
    logic        last_fbo = 1'b0;

    regfile_write_arbiter dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_hold            (hold),
        .i_req_valid       (req_valid),
        .i_req_addr        (req_addr),
        .i_req_data        (req_data),
        .i_req_byte        (req_byte),
        .o_req_ready       (req_ready),
        .o_write_enable_1  (we1),
        .o_write_addr_1    (wa1),
        .o_write_data_1    (wd1),
        .o_write_enable_2  (we2),
        .o_write_addr_2    (wa2),
        .o_write_data_2    (wd2),
        .o_first_byte_only (fbo),
        .o_pending_mask    (pend),
        .o_conflict        (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready"}, 64'(req_ready), 64'h0);
        chk({tag, " en1"},   64'(we1), 64'h0);
        chk({tag, " en2"},   64'(we2), 64'h0);
        chk({tag, " pend"},  64'(pend), 64'h0);
        chk({tag, " conf"},  64'(conflict), 64'h0);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("en1", 64'(we1), 64'(e.en1));
            chk("addr1", 64'(wa1), 64'(e.a1));
            chk("data1", 64'(wd1), 64'(e.d1));
            chk("en2", 64'(we2), 64'(e.en2));
            chk("addr2", 64'(wa2), 64'(e.a2));
            chk("data2", 64'(wd2), 64'(e.d2));
            chk("fbo", 64'(fbo), 64'(e.fbo));
            chk("pending", 64'(pend), 64'(e.pend));
            chk("conflict", 64'(conflict), 64'(e.conf));
        end
    endtask

    // Called at a falling edge: check last issue, drive v, check ready, queue expectation.
    task automatic step(input vec_t v);
        exp_t e;
        logic [3:0] rdy;
        sb_check();
        hold = v.hold; req_valid = v.valid; req_addr = v.addr;
        req_data = v.data; req_byte = v.byt;
        #1;
        rdy = 4'h0;
        if (v.a >= 0) rdy[v.a] = 1'b1;
        if (v.b >= 0) rdy[v.b] = 1'b1;
        chk("ready", 64'(req_ready), 64'(rdy));
        if (v.a >= 0) begin
            last_a1  = v.addr[v.a*4 +: 4];
            last_d1  = v.data[v.a*16 +: 16];
            last_fbo = v.byt[v.a];
        end
        if (v.b >= 0) begin
            last_a2 = v.addr[v.b*4 +: 4];
            last_d2 = v.data[v.b*16 +: 16];
        end
        e.en1  = (v.a >= 0);
        e.en2  = (v.b >= 0);
        e.a1   = last_a1;
        e.d1   = last_d1;
        e.a2   = last_a2;
        e.d2   = last_d2;
        e.fbo  = last_fbo;
        e.pend = (e.en1 ? (16'h1 << last_a1) : 16'h0) | (e.en2 ? (16'h1 << last_a2) : 16'h0);
        e.conf = v.conf;
        sb.push_back(e);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic h, input logic [3:0] vld, input logic [15:0] ad,
                                input logic [63:0] dt, input logic [3:0] by,
                                input int a, input int b, input logic cf);
        vec_t v;
        v.hold = h; v.valid = vld; v.addr = ad; v.data = dt; v.byt = by;
        v.a = a; v.b = b; v.conf = cf;
        return v;
    endfunction

    localparam logic [15:0] ALL_A = {4'hC, 4'h8, 4'h6, 4'h2};
    localparam logic [63:0] ALL_D = {16'hD003, 16'hC002, 16'hB001, 16'hA000};

    initial begin
        // fairness with all four valid, pointer alternating 0,2,0,2
        tbl.push_back(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 0, 1, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 2, 3, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 0, 1, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 2, 3, 1'b0));
        // dual issue D/FFFF and 9/AAAA
        tbl.push_back(mk(1'b0, 4'h5, {4'h0, 4'h9, 4'h0, 4'hD},
                         {16'h0, 16'hAAAA, 16'h0, 16'hFFFF}, 4'h0, 0, 2, 1'b0));
        // lone requester goes to port 1, pointer wraps back to 0
        tbl.push_back(mk(1'b0, 4'h8, {4'h7, 12'h0}, {16'h7777, 48'h0}, 4'h0, 3, -1, 1'b0));
        // address clash on R5: req1 alone, then req3
        tbl.push_back(mk(1'b0, 4'hA, {4'h5, 4'h0, 4'h5, 4'h0},
                         {16'h3535, 16'h0, 16'h1515, 16'h0}, 4'h0, 1, -1, 1'b1));
        tbl.push_back(mk(1'b0, 4'h8, {4'h5, 4'h0, 4'h5, 4'h0},
                         {16'h3535, 16'h0, 16'h1515, 16'h0}, 4'h0, 3, -1, 1'b0));
        // byte-mode mismatch: R3 byte-only first, R4 full word next
        tbl.push_back(mk(1'b0, 4'h3, {8'h0, 4'h4, 4'h3},
                         {32'h0, 16'h1234, 16'hAFAF}, 4'h1, 0, -1, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, {8'h0, 4'h4, 4'h3},
                         {32'h0, 16'h1234, 16'hAFAF}, 4'h1, 1, -1, 1'b0));
        // hold for three cycles, pointer frozen at 2
        tbl.push_back(mk(1'b1, 4'hF, ALL_A, ALL_D, 4'h0, -1, -1, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, ALL_A, ALL_D, 4'h0, -1, -1, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, ALL_A, ALL_D, 4'h0, -1, -1, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 2, 3, 1'b0));

        // reset held for two cycles with every requester valid
        rst = 1'b1; req_valid = 4'hF; req_addr = ALL_A; req_data = ALL_D;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_all_zero("reset");
            chk("reset addr1", 64'(wa1), 64'h0);
            chk("reset data2", 64'(wd2), 64'h0);
            chk("reset fbo", 64'(fbo), 64'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // mid-flight reset: grant 0/1 (pointer 0 -> 2), then pulse reset between edges
        step(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 0, 1, 1'b0));
        sb_check();
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        last_a1 = 4'h0; last_a2 = 4'h0; last_d1 = 16'h0; last_d2 = 16'h0; last_fbo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // pointer restarted at 0, so req0/req1 win rather than req2/req3
        step(mk(1'b0, 4'hF, ALL_A, ALL_D, 4'h0, 0, 1, 1'b0));
        sb_check();
        req_valid = 4'h0;
        @(negedge clk);
        chk("idle en1", 64'(we1), 64'h0);
        chk("idle en2", 64'(we2), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
